seg_display_driver: RTL

- Output-side counterpart of the switch/control decoder: takes the CPU's display selection and RAM display address and drives the board's 8-digit, active-low, multiplexed seven-segment display.
- Selects one 32-bit source per frame, fetching RAM words through a request/valid read port when needed.
- Shows the selected word as 8 hex digits. The pause state is shown on the decimal point of digit 0.

---
 rtl/seg_display_driver.sv | 138 +++++++++++++
 1 files changed

// File: rtl/seg_display_driver.sv
// Eight-digit active-low multiplexed seven-segment driver; shows one 32-bit
// source per frame and fetches RAM words over a request/valid read port.
module seg_display_driver #(
   parameter int unsigned SCAN_DIV    = 100000,
   parameter int unsigned RAM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  display_op,
   input  logic [9:0]  ram_display_addr,
   input  logic        pause,
   input  logic [31:0] pc_in,
   input  logic [31:0] cycle_cnt,
   input  logic [31:0] jump_cnt,
   input  logic [31:0] branch_cnt,
   input  logic [31:0] syscall_val,
   output logic        ram_rd_req,
   output logic [9:0]  ram_rd_addr,
   input  logic        ram_rd_valid,
   input  logic [31:0] ram_rd_data,
   output logic [7:0]  AN,
   output logic [7:0]  SEG
);

   localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned TMO_W  = (RAM_TIMEOUT > 1) ? $clog2(RAM_TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t              state;
   logic [SCAN_W-1:0]   scan_cnt;
   logic [2:0]          digit_idx;
   logic [31:0]         shown;
   logic [31:0]         ram_word;
   logic [TMO_W-1:0]    tmo;
   logic                scan_wrap;
   logic                frame_start;
   logic [31:0]         src;
   logic [3:0]          nib;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0:    return 7'h40;
         4'h1:    return 7'h79;
         4'h2:    return 7'h24;
         4'h3:    return 7'h30;
         4'h4:    return 7'h19;
         4'h5:    return 7'h12;
         4'h6:    return 7'h02;
         4'h7:    return 7'h78;
         4'h8:    return 7'h00;
         4'h9:    return 7'h10;
         4'hA:    return 7'h08;
         4'hB:    return 7'h03;
         4'hC:    return 7'h46;
         4'hD:    return 7'h21;
         4'hE:    return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   always_comb begin
      scan_wrap   = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
      frame_start = scan_wrap && (digit_idx == 3'd7);
      nib         = shown[{digit_idx, 2'b00} +: 4];
   end

   always_comb begin
      src = '0;
      case (display_op)
         3'd0:    src = pc_in;
         3'd1:    src = ram_word;
         3'd2:    src = cycle_cnt;
         3'd3:    src = jump_cnt;
         3'd4:    src = branch_cnt;
         3'd5:    src = syscall_val;
         default: src = '0;
      endcase
   end

   // AN/SEG follow digit_idx one cycle late, so a new frame's digit 0 sees the freshly latched word
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt  <= '0;
         digit_idx <= '0;
         shown     <= '0;
         AN        <= '1;
         SEG       <= '1;
      end else begin
         scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
         if (scan_wrap)
            digit_idx <= digit_idx + 3'd1;
         if (frame_start)
            shown <= src;
         AN  <= ~(8'b1 << digit_idx);
         SEG <= {~(pause && (digit_idx == 3'd0)), hex7(nib)};
      end
   end

   // Address is captured on entry to REQ so it is already valid during the request pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         ram_rd_req  <= 1'b0;
         ram_rd_addr <= '0;
         ram_word    <= '0;
         tmo         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (frame_start && (display_op == 3'd1)) begin
                  state       <= REQ;
                  ram_rd_req  <= 1'b1;
                  ram_rd_addr <= ram_display_addr;
               end
            end
            REQ: begin
               ram_rd_req <= 1'b0;
               tmo        <= '0;
               state      <= WAIT;
            end
            WAIT: begin
               if (ram_rd_valid) begin
                  ram_word <= ram_rd_data;
                  state    <= IDLE;
               end else if (tmo == TMO_W'(RAM_TIMEOUT - 1)) begin
                  ram_word <= 32'hEEEEEEEE;
                  state    <= IDLE;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
